sha256_core_mb: RTL

Multi-block, parametrised SHA-256 compression engine behind the same byte-wide register port as the single-block core.
- Adds digest chaining across 512-bit blocks, so messages longer than one block can be hashed.
- Adds a configurable number of rounds per clock, a sticky interrupt with enable/clear, and a block counter.
- Sits on the peripheral byte bus; host software does all padding.

---
 rtl/sha256_core_mb.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/sha256_core_mb.sv
`default_nettype none
// ============================================================================
// Module   : sha256_core_mb (with helper sha256_coefs)
// Purpose  : Multi-block SHA-256 compression engine on a byte-wide register
//            port. Chains the digest across 512-bit blocks, unrolls
//            ROUNDS_PER_CYCLE rounds per clock, and has a sticky done flag
//            with an interrupt enable and a block counter.
// Ports    : i_clk, i_rst_n (async, active low)
//            i_w_addr / i_data8 / i_we  - register address, write data, strobe
//            o_data_mux                 - combinational read data for i_w_addr
//            o_irq                      - done & irq_en
//            o_busy                     - high in ROUND and MATH
// Options  : define SHA224_EN to add CTRL bit6 (mode224) and the SHA-224 IV.
// Revision : 1.0 - initial release
// ============================================================================

// Round constant LUT; one instance per unrolled round.
module sha256_coefs (
    input  logic [5:0]  i_idx,
    output logic [31:0] o_k
);
    localparam logic [31:0] c_K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    assign o_k = c_K[i_idx];
endmodule

module sha256_core_mb #(
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter int ADDR_W           = 7
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [ADDR_W-1:0] i_w_addr,
    input  logic [7:0]        i_data8,
    input  logic              i_we,
    output logic [7:0]        o_data_mux,
    output logic              o_irq,
    output logic              o_busy
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ROUND = 2'd1;
    localparam logic [1:0] S_MATH  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [5:0]   c_LAST_CNT = 6'(64 - ROUNDS_PER_CYCLE);
    localparam logic [255:0] c_IV256 =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
`ifdef SHA224_EN
    localparam logic [255:0] c_IV224 =
        256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;
`endif

    if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4 ||
          ROUNDS_PER_CYCLE == 8 || ROUNDS_PER_CYCLE == 16)) begin : g_bad_rpc
        $error("ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    function automatic logic [31:0] big_s0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction
    function automatic logic [31:0] big_s1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction
    function automatic logic [31:0] sml_s0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction
    function automatic logic [31:0] sml_s1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
    endfunction

    logic [1:0]   state_q, state_d;
    logic [5:0]   cnt_q;
    logic [511:0] block_q;      // message block, doubles as the sliding schedule
    logic [255:0] work_q;       // working variables a..h; holds the digest when idle
    logic [255:0] hsave_q;      // chaining value added back in MATH
    logic [7:0]   blkcnt_q;
    logic         irq_en_q, chain_q, done_q;
    logic         w_m224;
`ifdef SHA224_EN
    logic         mode224_q;
    assign w_m224 = mode224_q;
`else
    assign w_m224 = 1'b0;
`endif

    logic         w_ctrl_we, w_msg_we, w_start;
    logic [255:0] w_init, w_work_nxt, w_sum;
    logic [511:0] w_sched_nxt;
    logic [31:0]  w_k [ROUNDS_PER_CYCLE];
    logic [4:0]   w_didx;

    assign w_ctrl_we = i_we && (i_w_addr == ADDR_W'(65));
    // The block register is shifting during a run, so message writes are only
    // taken while idle.
    assign w_msg_we  = i_we && (i_w_addr < ADDR_W'(64)) && (state_q == S_IDLE);
    assign w_start   = w_ctrl_we && i_data8[0] && (state_q == S_IDLE);

`ifdef SHA224_EN
    assign w_init = i_data8[1] ? work_q : (i_data8[6] ? c_IV224 : c_IV256);
`else
    assign w_init = i_data8[1] ? work_q : c_IV256;
`endif

    for (genvar r = 0; r < ROUNDS_PER_CYCLE; r++) begin : g_klut
        sha256_coefs u_coefs (
            .i_idx (cnt_q + 6'(r)),
            .o_k   (w_k[r])
        );
    end

    // Unrolled rounds; the top word of the schedule is W[t], and the newly
    // expanded W[t+16] is shifted in at the bottom.
    always_comb begin : p_rounds
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, wn;
        w_work_nxt  = work_q;
        w_sched_nxt = block_q;
        for (int r = 0; r < ROUNDS_PER_CYCLE; r++) begin
            {a, b, c, d, e, f, g, h} = w_work_nxt;
            t1 = h + big_s1(e) + ((e & f) ^ (~e & g)) + w_k[r] + w_sched_nxt[511:480];
            t2 = big_s0(a) + ((a & b) ^ (a & c) ^ (b & c));
            w_work_nxt = {t1 + t2, a, b, c, d + t1, e, f, g};
            wn = sml_s1(w_sched_nxt[63:32]) + w_sched_nxt[223:192]
               + sml_s0(w_sched_nxt[479:448]) + w_sched_nxt[511:480];
            w_sched_nxt = {w_sched_nxt[479:0], wn};
        end
    end

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < 8; i++) begin
            w_sum[32*i +: 32] = work_q[32*i +: 32] + hsave_q[32*i +: 32];
        end
    end

    // FSM: state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (w_start) state_d = S_ROUND;
            S_ROUND: if (cnt_q == c_LAST_CNT) state_d = S_MATH;
            S_MATH:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        o_busy = (state_q == S_ROUND) || (state_q == S_MATH);
        o_irq  = done_q && irq_en_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q     <= '0;
            block_q   <= '0;
            work_q    <= c_IV256;
            hsave_q   <= c_IV256;
            blkcnt_q  <= '0;
            irq_en_q  <= 1'b0;
            chain_q   <= 1'b0;
            done_q    <= 1'b0;
`ifdef SHA224_EN
            mode224_q <= 1'b0;
`endif
        end else begin
            if (w_msg_we)                block_q[{i_w_addr[5:0], 3'b000} +: 8] <= i_data8;
            else if (state_q == S_ROUND) block_q <= w_sched_nxt;

            if (w_ctrl_we) begin
                irq_en_q  <= i_data8[2];
                chain_q   <= i_data8[1];
`ifdef SHA224_EN
                mode224_q <= i_data8[6];
`endif
            end

            // A clear landing in the same cycle as the set loses.
            if (state_q == S_DONE)            done_q <= 1'b1;
            else if (w_ctrl_we && i_data8[3]) done_q <= 1'b0;

            if (w_start) begin
                cnt_q   <= '0;
                work_q  <= w_init;
                hsave_q <= w_init;
                if (!i_data8[1]) blkcnt_q <= '0;
            end else begin
                case (state_q)
                    S_ROUND: begin
                        work_q <= w_work_nxt;
                        cnt_q  <= cnt_q + 6'(ROUNDS_PER_CYCLE);
                    end
                    S_MATH:  work_q   <= w_sum;
                    S_DONE:  blkcnt_q <= blkcnt_q + 8'd1;
                    default: ;
                endcase
            end
        end
    end

    assign w_didx = 5'(i_w_addr - ADDR_W'(70));

    always_comb begin
        o_data_mux = 8'hAA;
        if (i_w_addr < ADDR_W'(64))       o_data_mux = 8'h00;
        else if (i_w_addr == ADDR_W'(64)) o_data_mux = 8'(ROUNDS_PER_CYCLE);
        else if (i_w_addr == ADDR_W'(65)) o_data_mux = {1'b0, w_m224, state_q, done_q, irq_en_q, chain_q, 1'b0};
        else if (i_w_addr == ADDR_W'(66)) o_data_mux = blkcnt_q;
        else if ((i_w_addr >= ADDR_W'(70)) && (i_w_addr <= ADDR_W'(101))) begin
            // H7 occupies bytes 0..3 and is hidden in SHA-224 mode.
            if (w_m224 && (w_didx < 5'd4)) o_data_mux = 8'h00;
            else                           o_data_mux = work_q[{w_didx, 3'b000} +: 8];
        end
    end
endmodule
`default_nettype wire
